// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR with seed load, all-zero lockup recovery,
// wrap detection against a reference seed, and step/period measurement.
//
// There is no valid/ready handshake on this block: en and load are
// single-cycle commands sampled at each rising clk edge. load has
// priority over en, and rst has priority over both. All outputs are
// registered, so no input reaches an output combinationally.
module lfsr_gen #(
    parameter int                 WIDTH    = 7,
    parameter logic [WIDTH-1:0]   TAPS     = 7'b1000100,
    parameter logic [WIDTH-1:0]   SEED_RST = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    output logic [WIDTH-1:0]   data_out,
    output logic               bit_out,
    output logic               wrap,
    output logic               lockup,
    output logic [CNT_W-1:0]   step_cnt,
    output logic [CNT_W-1:0]   period
);

    localparam logic [WIDTH-1:0] ZERO_STATE = '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Registered state.
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q,   ref_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] per_q,   per_d;
    logic             wrap_q,  wrap_d;
    logic             lock_q,  lock_d;

    // Combinational helpers for one normal step.
    logic             fb;
    logic [WIDTH-1:0] step_next;
    logic [CNT_W-1:0] cnt_inc;

    // Feedback, shifted next state and saturating step count.
    always_comb begin
        fb        = ^(state_q & TAPS);
        step_next = {state_q[WIDTH-2:0], fb};
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    end

    // Next-state selection: load beats en; otherwise everything holds
    // and the event pulses drop back to zero.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        wrap_d  = 1'b0;
        lock_d  = 1'b0;

        if (load) begin
            // A zero seed would lock the register up, so it is replaced by
            // SEED_RST and reported as a lockup event. The step of a
            // simultaneous en is dropped.
            cnt_d = '0;
            if (seed != ZERO_STATE) begin
                state_d = seed;
                ref_d   = seed;
            end else begin
                state_d = SEED_RST;
                ref_d   = SEED_RST;
                lock_d  = 1'b1;
            end
        end else if (en) begin
            if (state_q == ZERO_STATE) begin
                // Corrupted all-zero state: restart from SEED_RST. ref is
                // kept, and this is never reported as a wrap.
                state_d = SEED_RST;
                cnt_d   = '0;
                lock_d  = 1'b1;
            end else begin
                state_d = step_next;
                if (step_next == ref_q) begin
                    // Cycle closed: publish its length and start over.
                    wrap_d = 1'b1;
                    per_d  = cnt_inc;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = cnt_inc;
                end
            end
        end
    end

    // State register with synchronous reset; reset also discards any
    // pulse or command from the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_RST;
            ref_q   <= SEED_RST;
            cnt_q   <= '0;
            per_q   <= '0;
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            wrap_q  <= wrap_d;
            lock_q  <= lock_d;
        end
    end

    // Outputs come straight from registers.
    assign data_out = state_q;
    assign bit_out  = state_q[WIDTH-1];
    assign wrap     = wrap_q;
    assign lockup   = lock_q;
    assign step_cnt = cnt_q;
    assign period   = per_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen. The main instance uses the
// default x^7+x^3+1 configuration; a small 3-bit instance with a
// degenerate tap set is used to reach the all-zero state and to
// saturate the step counter.
module tb_lfsr_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (defaults).
    logic       en, load;
    logic [6:0] seed;
    logic [6:0] data_out;
    logic       bit_out, wrap, lockup;
    logic [15:0] step_cnt, period;

    lfsr_gen dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
        .data_out(data_out), .bit_out(bit_out), .wrap(wrap),
        .lockup(lockup), .step_cnt(step_cnt), .period(period)
    );

    // Small instance: fb = state[0], so 100 shifts to 000 and 001 runs
    // 011 -> 111 -> 111 ..., never returning to its reference seed.
    logic       en2, load2;
    logic [2:0] seed2;
    logic [2:0] data2;
    logic       bit2, wrap2, lock2;
    logic [2:0] cnt2, per2;

    lfsr_gen #(.WIDTH(3), .TAPS(3'b001), .SEED_RST(3'b001), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .load(load2), .seed(seed2),
        .data_out(data2), .bit_out(bit2), .wrap(wrap2),
        .lockup(lock2), .step_cnt(cnt2), .period(per2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^7+x^3+1 reference step: feedback from bits 6 and 2, shift up.
    function automatic logic [6:0] ref_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[2]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0;
        en2 = 1'b0; load2 = 1'b0; seed2 = '0;

        // Reset state.
        tick();
        rst = 1'b0;
        check("rst_data",   32'(data_out), 32'h01);
        check("rst_bit",    32'(bit_out),  32'h0);
        check("rst_cnt",    32'(step_cnt), 32'h0);
        check("rst_period", 32'(period),   32'h0);
        check("rst_wrap",   32'(wrap),     32'h0);
        check("rst_lockup", 32'(lockup),   32'h0);

        // Six steps from seed 01 (hand-computed sequence).
        exp_q = '{7'h02, 7'h04, 7'h09, 7'h12, 7'h24, 7'h49};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("seq6_data", 32'(data_out), 32'(exp_q.pop_front()));
            check("seq6_wrap", 32'(wrap), 32'h0);
        end
        check("seq6_cnt", 32'(step_cnt), 32'd6);
        check("seq6_bit", 32'(bit_out),  32'h1);

        // Hold: nothing moves, no pulses.
        en = 1'b0;
        tick();
        check("hold_data", 32'(data_out), 32'h49);
        check("hold_cnt",  32'(step_cnt), 32'd6);
        check("hold_wrap", 32'(wrap),     32'h0);
        check("hold_lock", 32'(lockup),   32'h0);

        // Full 127-step cycle from reset seed.
        do_reset();
        model = 7'h01;
        en = 1'b1;
        for (int i = 1; i <= 127; i++) begin
            tick();
            model = ref_step(model);
            check("full_data", 32'(data_out), 32'(model));
            check("full_wrap", 32'(wrap), (i == 127) ? 32'h1 : 32'h0);
        end
        check("full_end_data", 32'(data_out), 32'h01);
        check("full_period",   32'(period),   32'd127);
        check("full_cnt",      32'(step_cnt), 32'd0);
        en = 1'b0;
        tick();
        check("wrap_one_cycle", 32'(wrap),   32'h0);
        check("period_hold",    32'(period), 32'd127);

        // Load 55, then run a full cycle back to it.
        load = 1'b1; seed = 7'h55;
        tick();
        load = 1'b0;
        check("ld55_data",   32'(data_out), 32'h55);
        check("ld55_cnt",    32'(step_cnt), 32'd0);
        check("ld55_period", 32'(period),   32'd127);
        check("ld55_lock",   32'(lockup),   32'h0);
        model = 7'h55;
        en = 1'b1;
        for (int i = 1; i <= 127; i++) begin
            tick();
            model = ref_step(model);
            check("run55_data", 32'(data_out), 32'(model));
            check("run55_wrap", 32'(wrap), (i == 127) ? 32'h1 : 32'h0);
        end
        check("run55_end",    32'(data_out), 32'h55);
        check("run55_period", 32'(period),   32'd127);
        en = 1'b0;

        // Load of zero seed: recovers to SEED_RST with a lockup pulse.
        load = 1'b1; seed = 7'h00;
        tick();
        load = 1'b0;
        check("ld0_data", 32'(data_out), 32'h01);
        check("ld0_lock", 32'(lockup),   32'h1);
        check("ld0_wrap", 32'(wrap),     32'h0);
        check("ld0_cnt",  32'(step_cnt), 32'd0);
        tick();
        check("ld0_lock_drop", 32'(lockup), 32'h0);

        // load together with en: load only, no shift.
        load = 1'b1; en = 1'b1; seed = 7'h10;
        tick();
        load = 1'b0;
        check("ld_en_data", 32'(data_out), 32'h10);
        check("ld_en_cnt",  32'(step_cnt), 32'd0);
        tick();
        check("after_ld_data", 32'(data_out), 32'h20);
        check("after_ld_cnt",  32'(step_cnt), 32'd1);
        en = 1'b0;

        // Reset at step 60 with en still high.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        check("pre_rst_cnt", 32'(step_cnt), 32'd60);
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        check("mid_rst_data",   32'(data_out), 32'h01);
        check("mid_rst_cnt",    32'(step_cnt), 32'd0);
        check("mid_rst_period", 32'(period),   32'd0);
        check("mid_rst_wrap",   32'(wrap),     32'h0);
        check("mid_rst_lock",   32'(lockup),   32'h0);

        // Small instance: zero-state recovery, then counter saturation.
        load2 = 1'b1; seed2 = 3'b100;
        tick();
        load2 = 1'b0;
        check("s_ld_data", 32'(data2), 32'h4);
        check("s_ld_bit",  32'(bit2),  32'h1);
        en2 = 1'b1;
        tick();
        check("s_zero_data", 32'(data2), 32'h0);
        check("s_zero_cnt",  32'(cnt2),  32'd1);
        check("s_zero_lock", 32'(lock2), 32'h0);
        tick();
        check("s_rec_data", 32'(data2), 32'h1);
        check("s_rec_cnt",  32'(cnt2),  32'd0);
        check("s_rec_lock", 32'(lock2), 32'h1);
        check("s_rec_wrap", 32'(wrap2), 32'h0);
        tick();
        check("s_step_data",   32'(data2), 32'h3);
        check("s_lock_dropped", 32'(lock2), 32'h0);
        for (int i = 0; i < 10; i++) tick();
        check("s_sat_data",   32'(data2), 32'h7);
        check("s_sat_cnt",    32'(cnt2),  32'd7);
        check("s_sat_period", 32'(per2),  32'd0);
        check("s_sat_wrap",   32'(wrap2), 32'h0);
        en2 = 1'b0;

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
